// File: rtl/i2c_frame_timer.sv
// I2C slave frame timer: sequences data bits and the ACK slot between START and STOP.
// Define I2C_FRAME_TIMER_TIMEOUT_EN to add the SCL-stall timeout abort.
module i2c_frame_timer #(
  parameter int DATA_BITS      = 8,
  parameter int CNT_W          = $clog2(DATA_BITS + 1),
  parameter int FRAME_CNT_W    = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   rising_edge,
  input  logic                   falling_edge,
  output logic                   byte_received,
  output logic                   ack_prep,
  output logic                   ack_check,
  output logic                   ack_done,
  output logic                   sample_strobe,
  output logic [CNT_W-1:0]       bit_index,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   busy,
  output logic                   timeout
);

  if (DATA_BITS < 1 || DATA_BITS > 32) begin : g_bad_data_bits
    $error("i2c_frame_timer: DATA_BITS must be within 1..32");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("i2c_frame_timer: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_START_FALL = 3'd1,
    S_DATA       = 3'd2,
    S_DATA_END   = 3'd3,
    S_ACK_HIGH   = 3'd4,
    S_ACK_LOW    = 3'd5
  } state_t;

  state_t                 state_r;
  logic                   busy_r;
  logic                   byte_received_r;
  logic                   ack_prep_r;
  logic                   ack_check_r;
  logic                   ack_done_r;
  logic                   sample_strobe_r;
  logic                   timeout_r;
  logic [CNT_W-1:0]       bit_index_r;
  logic [FRAME_CNT_W-1:0] frame_count_r;
  logic                   rise_s;
  logic                   fall_s;
  logic                   stall_s;

  // Coincident edge strobes are contradictory, so neither is acted on.
  assign rise_s = rising_edge & ~falling_edge;
  assign fall_s = falling_edge & ~rising_edge;

`ifdef I2C_FRAME_TIMER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] stall_cnt_r;

  assign stall_s = busy_r & ~start & ~rising_edge & ~falling_edge &
                   (stall_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));

  // Stall counter: counts idle clocks while a frame is in progress.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stall_cnt_r <= '0;
    end else if (!busy_r || start || stop || rising_edge || falling_edge || stall_s) begin
      stall_cnt_r <= '0;
    end else begin
      stall_cnt_r <= stall_cnt_r + TO_W'(1);
    end
  end
`else
  assign stall_s = 1'b0;
`endif

  // Frame sequencer: priority stop > start > stall abort > SCL edges.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r         <= S_IDLE;
      busy_r          <= 1'b0;
      byte_received_r <= 1'b0;
      ack_prep_r      <= 1'b0;
      ack_check_r     <= 1'b0;
      ack_done_r      <= 1'b0;
      sample_strobe_r <= 1'b0;
      timeout_r       <= 1'b0;
      bit_index_r     <= '0;
      frame_count_r   <= '0;
    end else begin
      byte_received_r <= 1'b0;
      ack_prep_r      <= 1'b0;
      ack_check_r     <= 1'b0;
      ack_done_r      <= 1'b0;
      sample_strobe_r <= 1'b0;
      timeout_r       <= 1'b0;
      if (stop) begin
        state_r       <= S_IDLE;
        busy_r        <= 1'b0;
        bit_index_r   <= '0;
        frame_count_r <= '0;
      end else if (start) begin
        state_r     <= S_START_FALL;
        busy_r      <= 1'b1;
        bit_index_r <= '0;
      end else if (stall_s) begin
        state_r       <= S_IDLE;
        busy_r        <= 1'b0;
        timeout_r     <= 1'b1;
        bit_index_r   <= '0;
        frame_count_r <= '0;
      end else begin
        case (state_r)
          S_IDLE: begin
            busy_r <= 1'b0;
          end
          S_START_FALL: begin
            if (fall_s) begin
              state_r     <= S_DATA;
              bit_index_r <= '0;
            end
          end
          S_DATA: begin
            if (rise_s) begin
              sample_strobe_r <= 1'b1;
              bit_index_r     <= bit_index_r + CNT_W'(1);
              if (bit_index_r == CNT_W'(DATA_BITS - 1)) begin
                state_r <= S_DATA_END;
              end
            end
          end
          S_DATA_END: begin
            if (fall_s) begin
              byte_received_r <= 1'b1;
              ack_prep_r      <= 1'b1;
              state_r         <= S_ACK_HIGH;
            end
          end
          S_ACK_HIGH: begin
            if (rise_s) begin
              ack_check_r <= 1'b1;
              state_r     <= S_ACK_LOW;
            end
          end
          S_ACK_LOW: begin
            if (fall_s) begin
              ack_done_r  <= 1'b1;
              bit_index_r <= '0;
              state_r     <= S_DATA;
              if (frame_count_r != {FRAME_CNT_W{1'b1}}) begin
                frame_count_r <= frame_count_r + FRAME_CNT_W'(1);
              end
            end
          end
          default: begin
            state_r     <= S_IDLE;
            busy_r      <= 1'b0;
            bit_index_r <= '0;
          end
        endcase
      end
    end
  end

  assign byte_received = byte_received_r;
  assign ack_prep      = ack_prep_r;
  assign ack_check     = ack_check_r;
  assign ack_done      = ack_done_r;
  assign sample_strobe = sample_strobe_r;
  assign bit_index     = bit_index_r;
  assign frame_count   = frame_count_r;
  assign busy          = busy_r;
  assign timeout       = timeout_r;

endmodule

// File: tb/tb_i2c_frame_timer.sv
// Directed self-checking bench for i2c_frame_timer (DATA_BITS=8, TIMEOUT_CYCLES=50).
module tb_i2c_frame_timer;

  localparam int DB  = 8;
  localparam int CW  = $clog2(DB + 1);
  localparam int FW  = 8;
  localparam int TOC = 50;

  logic          tb_clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          rising_edge = 1'b0;
  logic          falling_edge = 1'b0;
  logic          byte_received;
  logic          ack_prep;
  logic          ack_check;
  logic          ack_done;
  logic          sample_strobe;
  logic [CW-1:0] bit_index;
  logic [FW-1:0] frame_count;
  logic          busy;
  logic          timeout;

  int errors = 0;
  int checks = 0;

  i2c_frame_timer #(
    .DATA_BITS(DB),
    .FRAME_CNT_W(FW),
    .TIMEOUT_CYCLES(TOC)
  ) dut (
    .clk(tb_clk),
    .n_rst(n_rst),
    .start(start),
    .stop(stop),
    .rising_edge(rising_edge),
    .falling_edge(falling_edge),
    .byte_received(byte_received),
    .ack_prep(ack_prep),
    .ack_check(ack_check),
    .ack_done(ack_done),
    .sample_strobe(sample_strobe),
    .bit_index(bit_index),
    .frame_count(frame_count),
    .busy(busy),
    .timeout(timeout)
  );

  always #5 tb_clk = ~tb_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic s, input logic p, input logic r, input logic f);
    @(negedge tb_clk);
    start = s; stop = p; rising_edge = r; falling_edge = f;
    @(posedge tb_clk);
    #1;
    start = 1'b0; stop = 1'b0; rising_edge = 1'b0; falling_edge = 1'b0;
  endtask

  task automatic begin_frame();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("start_busy", busy, 1);
    chk("start_bit_index", bit_index, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("start_fall_no_sample", sample_strobe, 0);
    chk("start_fall_bit_index", bit_index, 0);
  endtask

  task automatic data_bits(input int n, input int base);
    for (int i = 1; i <= n; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("sample_strobe", sample_strobe, 1);
      chk("bit_index", bit_index, base + i);
      chk("no_byte_on_rise", byte_received, 0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("sample_low", sample_strobe, 0);
      chk("byte_received", byte_received, (base + i == DB) ? 1 : 0);
      chk("ack_prep", ack_prep, (base + i == DB) ? 1 : 0);
    end
  endtask

  task automatic ack_slot(input int exp_frames);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ack_check", ack_check, 1);
    chk("ack_rise_no_sample", sample_strobe, 0);
    chk("ack_rise_no_done", ack_done, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ack_done", ack_done, 1);
    chk("ack_fall_no_check", ack_check, 0);
    chk("frame_count", frame_count, exp_frames);
    chk("ack_bit_index", bit_index, 0);
  endtask

  initial begin
    int pulses;
    int pulse_at;

    // Reset state
    repeat (3) @(posedge tb_clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_bit_index", bit_index, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_strobes", {byte_received, ack_prep, ack_check, ack_done, sample_strobe}, 0);
    @(negedge tb_clk);
    n_rst = 1'b1;

    // Edges in IDLE are ignored
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("idle_rise_no_sample", sample_strobe, 0);
    chk("idle_busy", busy, 0);

    // One full frame
    begin_frame();
    data_bits(DB, 0);
    chk("data_end_bit_index", bit_index, DB);
    ack_slot(1);

    // Two more frames, then STOP
    data_bits(DB, 0);
    ack_slot(2);
    data_bits(DB, 0);
    ack_slot(3);
    chk("pre_stop_frames", frame_count, 3);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("stop_frames", frame_count, 0);
    chk("stop_busy", busy, 0);
    chk("stop_no_strobe", ack_done, 0);

    // Repeated START after bit 4 of frame 2
    begin_frame();
    data_bits(DB, 0);
    ack_slot(1);
    data_bits(4, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rstart_bit_index", bit_index, 0);
    chk("rstart_frames", frame_count, 1);
    chk("rstart_busy", busy, 1);
    // START-phase rising edge is not a data bit
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("start_fall_rise_ignored", sample_strobe, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    data_bits(DB, 0);
    ack_slot(2);

    // Coincident edges in DATA, then a stray rising edge in DATA_END
    data_bits(2, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("both_edges_bit_index", bit_index, 2);
    chk("both_edges_no_sample", sample_strobe, 0);
    data_bits(DB - 3, 2);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("last_sample", sample_strobe, 1);
    chk("last_bit_index", bit_index, DB);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("data_end_rise_ignored", sample_strobe, 0);
    chk("data_end_rise_no_byte", byte_received, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("data_end_byte", byte_received, 1);
    chk("data_end_ack_prep", ack_prep, 1);
    ack_slot(3);

    // Simultaneous START and STOP
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("start_stop_busy", busy, 0);
    chk("start_stop_frames", frame_count, 0);
    chk("start_stop_bit_index", bit_index, 0);

    // SCL stall after bit 3
    begin_frame();
    data_bits(3, 0);
    pulses = 0;
    pulse_at = 0;
    for (int j = 1; j <= TOC + 10; j++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (timeout === 1'b1) begin
        pulses++;
        pulse_at = j;
      end
    end
`ifdef I2C_FRAME_TIMER_TIMEOUT_EN
    chk("timeout_pulses", pulses, 1);
    chk("timeout_cycle", pulse_at, TOC);
    chk("timeout_busy", busy, 0);
    chk("timeout_bit_index", bit_index, 0);
`else
    chk("no_timeout_pulses", pulses, 0);
    chk("stall_busy_holds", busy, 1);
    chk("stall_bit_index_holds", bit_index, 3);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("stall_stop_busy", busy, 0);
`endif

    // Frame counter saturates at 255
    begin_frame();
    for (int k = 1; k <= 256; k++) begin
      data_bits(DB, 0);
      ack_slot((k > 255) ? 255 : k);
    end
    chk("saturated_frames", frame_count, 255);

    // Asynchronous reset mid-frame at bit 5
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    data_bits(4, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("pre_reset_bit_index", bit_index, 5);
    chk("pre_reset_frames", frame_count, 255);
    #2;
    n_rst = 1'b0;
    #1;
    chk("async_rst_bit_index", bit_index, 0);
    chk("async_rst_frames", frame_count, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_sample", sample_strobe, 0);
    @(negedge tb_clk);
    n_rst = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("post_rst_idle", busy, 0);
    chk("post_rst_no_sample", sample_strobe, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
